// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: aligns requests onto a word-wide SRAM port,
// stalls the pipeline for the access, extracts and extends loads, and times out hung accesses.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_gnt,
  input  logic        data_sram_rvalid,
  input  logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_RESP} state_e;

  localparam logic [7:0] WD_LIMIT = 8'hFF;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  wd_q, wd_d;

  logic        aligned;
  logic        accept;
  logic        misalign_c;
  logic [3:0]  lane_wen;
  logic [31:0] lane_wdata;

  function automatic logic [31:0] extract(input logic [1:0] size, input logic sext,
                                          input logic [1:0] lane, input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = lane[1] ? raw[31:16] : raw[15:0];
    case (size)
      2'b00:   r = {{24{sext & b[7]}}, b};
      2'b01:   r = {{16{sext & h[15]}}, h};
      default: r = raw;
    endcase
    return r;
  endfunction

  always_comb begin
    case (req_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~req_addr[0];
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Store data is replicated across lanes once, at acceptance, so REQ just replays it.
  always_comb begin
    case (req_size)
      2'b00: begin
        lane_wen   = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_wen   = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_wen   = 4'b1111;
        lane_wdata = req_wdata;
      end
    endcase
    if (!req_we) lane_wen = 4'b0000;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wd_d       = wd_q;
    accept     = 1'b0;
    misalign_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid && aligned) begin
          accept  = 1'b1;
          we_d    = req_we;
          size_d  = req_size;
          sext_d  = req_sext;
          addr_d  = req_addr;
          wen_d   = lane_wen;
          wdata_d = lane_wdata;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          wd_d    = 8'd0;
          state_d = S_REQ;
        end else if (req_valid) begin
          misalign_c = 1'b1;
        end
      end
      S_REQ: begin
        wd_d = wd_q + 8'd1;
        // A grant landing on the expiry cycle still completes the access normally.
        if (data_sram_gnt) begin
          wd_d    = 8'd0;
          state_d = we_q ? S_RESP : S_WAIT_R;
        end else if (wd_q == WD_LIMIT) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = S_RESP;
        end
      end
      S_WAIT_R: begin
        wd_d = wd_q + 8'd1;
        if (data_sram_rvalid) begin
          rdata_d = extract(size_q, sext_q, addr_q[1:0], data_sram_rdata);
          state_d = S_RESP;
        end else if (wd_q == WD_LIMIT) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the async reset clears every latched field
  // so an abandoned access leaves nothing behind on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= 32'd0;
      wen_q   <= 4'b0000;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      wd_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  // Input-dependent outputs are gated by rst so they drop in the same cycle reset rises.
  assign stallreq        = ~rst & (accept | (state_q == S_REQ) | (state_q == S_WAIT_R));
  assign misalign        = ~rst & misalign_c;
  assign data_sram_en    = (state_q == S_REQ);
  assign data_sram_wen   = (state_q == S_REQ) ? wen_q : 4'b0000;
  assign data_sram_addr  = {addr_q[31:2], 2'b00};
  assign data_sram_wdata = wdata_q;
  assign resp_valid      = (state_q == S_RESP);
  assign resp_rdata      = (state_q == S_RESP) ? rdata_q : 32'd0;
  assign bus_err         = (state_q == S_RESP) & err_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 req_valid  in  1  memory-stage load/store request present.
REQ-004 req_we  in  1  1 = store, 0 = load.
REQ-005 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-006 req_sext  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data, right-aligned.
REQ-009 data_sram_en  out  1  SRAM access request.
REQ-010 data_sram_wen  out  4  byte-lane write enables; 0000 for loads.
REQ-011 data_sram_addr  out  32  word-aligned address {req_addr[31:2],2'b00}.
REQ-012 data_sram_wdata  out  32  lane-replicated store data.
REQ-013 data_sram_gnt  in  1  SRAM accepted current request this cycle.
REQ-014 data_sram_rvalid  in  1  load data valid on data_sram_rdata.
REQ-015 data_sram_rdata  in  32  raw SRAM word.
REQ-016 stallreq  out  1  pipeline stall request to the stall controller.
REQ-017 resp_valid  out  1  one-cycle completion pulse.
REQ-018 resp_rdata  out  32  extracted, extended load data; 0 for stores.
REQ-019 misalign  out  1  one-cycle pulse for misaligned/reserved-size request.
REQ-020 bus_err  out  1  one-cycle pulse with resp_valid on watchdog timeout.

Function
REQ-021 The block SHALL implement FSM states IDLE, REQ, WAIT_R, RESP.
REQ-022 Aligned = word: addr[1:0]==00; half: addr[0]==0; byte: always; size 11 never aligned.
REQ-023 IDLE: req_valid and aligned SHALL latch all request fields and go to REQ next cycle.
REQ-024 IDLE: req_valid and not aligned SHALL pulse misalign for that cycle (combinational), issue no SRAM access, and remain IDLE.
REQ-025 REQ: data_sram_en=1, with addr/wen/wdata driven from latched fields and held stable until data_sram_gnt.
REQ-026 REQ with gnt: store goes to RESP; load goes to WAIT_R; data_sram_en deasserts the following cycle.
REQ-027 data_sram_rvalid SHALL be sampled only in WAIT_R; rvalid in any other state is ignored.
REQ-028 WAIT_R with rvalid: capture extracted data into resp_rdata and go to RESP.
REQ-029 RESP: resp_valid=1 for exactly one cycle, then IDLE; new requests are accepted only in IDLE, never in RESP.
REQ-030 stallreq = (IDLE and req_valid and aligned) or REQ or WAIT_R; 0 in RESP and after a misaligned request.
REQ-031 Store lanes: byte wen=0001<<addr[1:0], wdata={4{b}}; half wen=addr[1]?1100:0011, wdata={2{h}}; word wen=1111, wdata=req_wdata.
REQ-032 Load extraction: byte lane addr[1:0], half lane addr[1], extended to 32 bits per req_sext.
REQ-033 An 8-bit watchdog SHALL clear on entering REQ or WAIT_R, increment every cycle in those states, and on reaching 255 force RESP with bus_err=1, resp_rdata=0.
REQ-034 gnt and watchdog expiry in the same cycle: gnt wins.

Reset
REQ-035 rst asserted SHALL immediately force IDLE, clear latched fields and watchdog, and drive all outputs 0, including mid-transaction; the abandoned access produces no resp_valid.

Verification
REQ-036 sw word 0x1234_5678 @0x100, gnt after 2 cycles -> wen=1111, addr=0x100, stallreq 1 for 4 cycles, resp_valid at cycle 4.
REQ-037 lb @0x103 sext=1, rdata=0x80FF_FFFF, rvalid 3 cycles after gnt -> resp_rdata=0xFFFF_FF80; lbu -> 0x0000_0080.
REQ-038 sh 0xABCD @0x102 -> wen=1100, wdata=0xABCD_ABCD; lh @0x101 -> misalign pulse, data_sram_en never 1.
REQ-039 load, gnt never asserted -> bus_err and resp_valid together 256 cycles after entering REQ, resp_rdata=0.
REQ-040 rst asserted in WAIT_R -> all outputs 0 same cycle, no later resp_valid; next lw completes normally.
